// File: rtl/game_pkg.sv
// Shared encodings and screen limits for the game mode sequencer.
package game_pkg;

  typedef logic [1:0] mode_t;

  // Mode FSM state encoding
  localparam logic [1:0] MODE_MENU = 2'd0;
  localparam logic [1:0] MODE_GAME = 2'd1;
  localparam logic [1:0] MODE_OVER = 2'd2;

  // Bound sequencer steps: a strobe on each even count, idle cycle between
  localparam logic [2:0] STEP_MIN_X = 3'd0;
  localparam logic [2:0] STEP_MAX_X = 3'd2;
  localparam logic [2:0] STEP_MIN_Y = 3'd4;
  localparam logic [2:0] STEP_MAX_Y = 3'd6;
  localparam logic [2:0] STEP_LAST  = 3'd6;

  // Full-screen limits, also used by draw_background
  localparam logic [11:0] SCREEN_MAX_X = 12'd1023;
  localparam logic [11:0] SCREEN_MAX_Y = 12'd767;

endpackage

// File: rtl/game_mode_controller_if.sv
// Mode outputs plus the MouseCtl bound-write bus.
interface game_mode_controller_if;
  logic        menu_on;
  logic        game_on;
  logic        over_on;
  logic        setmin_x;
  logic        setmax_x;
  logic        setmin_y;
  logic        setmax_y;
  logic [11:0] value;
  logic        cfg_busy;

  modport master (
    output menu_on, game_on, over_on,
    output setmin_x, setmax_x, setmin_y, setmax_y, value, cfg_busy
  );

  modport slave (
    input menu_on, game_on, over_on,
    input setmin_x, setmax_x, setmin_y, setmax_y, value, cfg_busy
  );
endinterface

// File: rtl/game_mode_controller_debouncer.sv
// Button debouncer: 2-flop synchronizer, stability counter, press pulse.
module button_debouncer #(
  parameter int CYCLES = 650000
)(
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // Accept a new level after CYCLES consecutive differing samples; pulse on rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= 2'b00;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync[1];
        cnt   <= '0;
        press <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/game_mode_controller.sv
// Game mode sequencer: debounced buttons, MENU/GAME/OVER FSM committed at
// vblank start, and the MouseCtl cursor-bound write sequence.
module game_mode_controller
  import game_pkg::*;
#(
  parameter int MIN_X           = 361,
  parameter int MAX_X           = 661,
  parameter int MIN_Y           = 367,
  parameter int MAX_Y           = 667,
  parameter int DEBOUNCE_CYCLES = 650000
)(
  input  logic pclk,
  input  logic rst,
  input  logic game_button,
  input  logic menu_button,
  input  logic hit,
  input  logic vblnk,
  game_mode_controller_if.master disp
);

  logic  game_press, menu_press;
  mode_t state, pend_mode, req_mode;
  logic  pend_vld, req_vld;
  logic  vblnk_prev;
  logic  commit;
  logic  seq_act, seq_game;
  logic [2:0] seq_cnt;

  button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_game_db (
    .clk(pclk), .rst(rst), .raw(game_button), .press(game_press)
  );

  button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_menu_db (
    .clk(pclk), .rst(rst), .raw(menu_button), .press(menu_press)
  );

  // Legal request from the current mode; later assignments win (menu > hit > game)
  always_comb begin
    req_vld  = 1'b0;
    req_mode = MODE_MENU;
    if (game_press && state != MODE_GAME) begin
      req_vld  = 1'b1;
      req_mode = MODE_GAME;
    end
    if (hit && state == MODE_GAME) begin
      req_vld  = 1'b1;
      req_mode = MODE_OVER;
    end
    if (menu_press && state != MODE_MENU) begin
      req_vld  = 1'b1;
      req_mode = MODE_MENU;
    end
  end

  // Commit only on a vblank rise with no bound sequence running
  assign commit = pend_vld && vblnk && !vblnk_prev && !seq_act;

  // Mode FSM and single-entry pending request (newest request overwrites)
  always_ff @(posedge pclk) begin
    if (rst) begin
      state      <= MODE_MENU;
      pend_vld   <= 1'b0;
      pend_mode  <= MODE_MENU;
      vblnk_prev <= 1'b0;
    end else begin
      vblnk_prev <= vblnk;
      if (commit) begin
        state    <= pend_mode;
        pend_vld <= 1'b0;
      end else if (req_vld) begin
        pend_vld  <= 1'b1;
        pend_mode <= req_mode;
      end
    end
  end

  // Bound sequencer: armed by reset (menu bounds) and restarted by each commit
  always_ff @(posedge pclk) begin
    if (rst) begin
      seq_act  <= 1'b1;
      seq_cnt  <= 3'd0;
      seq_game <= 1'b0;
    end else if (commit) begin
      seq_act  <= 1'b1;
      seq_cnt  <= 3'd0;
      seq_game <= (pend_mode == MODE_GAME);
    end else if (seq_act) begin
      if (seq_cnt == STEP_LAST) begin
        seq_act <= 1'b0;
        seq_cnt <= 3'd0;
      end else begin
        seq_cnt <= seq_cnt + 3'd1;
      end
    end
  end

  // Strobe/value decode; held quiet while rst is high so the first step
  // lands in the first cycle after release
  always_comb begin
    disp.setmin_x = 1'b0;
    disp.setmax_x = 1'b0;
    disp.setmin_y = 1'b0;
    disp.setmax_y = 1'b0;
    disp.value    = 12'd0;
    disp.cfg_busy = seq_act && !rst;
    if (seq_act && !rst) begin
      case (seq_cnt)
        STEP_MIN_X: begin
          disp.setmin_x = 1'b1;
          disp.value    = seq_game ? 12'(MIN_X) : 12'd0;
        end
        STEP_MAX_X: begin
          disp.setmax_x = 1'b1;
          disp.value    = seq_game ? 12'(MAX_X) : SCREEN_MAX_X;
        end
        STEP_MIN_Y: begin
          disp.setmin_y = 1'b1;
          disp.value    = seq_game ? 12'(MIN_Y) : 12'd0;
        end
        STEP_MAX_Y: begin
          disp.setmax_y = 1'b1;
          disp.value    = seq_game ? 12'(MAX_Y) : SCREEN_MAX_Y;
        end
        default: ;
      endcase
    end
  end

  assign disp.menu_on = (state == MODE_MENU);
  assign disp.game_on = (state == MODE_GAME);
  assign disp.over_on = (state == MODE_OVER);

endmodule
